// File: rtl/lut_stream_ctrl.sv
// Frame sequencer for the rectification LUT path: walks the LUT ROM once per
// frame and streams the offset bytes through a small prefetch FIFO.
module lut_stream_ctrl #(
    parameter int img_width  = 16,
    parameter int img_height = 8,
    parameter int LUT_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Fsync,
    output logic              lut_rd_en,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [7:0]        lut_rdata,
    output logic [7:0]        ltdata,
    output logic              ltvalid,
    output logic              ltlast,
    input  logic              ltready,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              fsync_err
);

    localparam int CNT_W = LUT_AW + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;

    localparam logic [CNT_W-1:0]  N_C         = CNT_W'(img_width * img_height);
    localparam logic [CNT_W-1:0]  LAST_C      = CNT_W'(img_width * img_height - 1);
    localparam logic [LUT_AW-1:0] LAST_ADDR_C = LUT_AW'(img_width * img_height - 1);
    localparam logic [FCW:0]      CRED_MAX_C  = (FCW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [LUT_AW-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      pop_cnt_q, pop_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [7:0]            mem_data_q [FIFO_DEPTH];
    logic [7:0]            mem_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q, mem_last_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]        count_q, count_d;
    logic                  ltvalid_q, ltvalid_d;
    logic [7:0]            ltdata_q, ltdata_d;
    logic                  ltlast_q, ltlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  start_s;
    logic                  pop_s;
    logic                  push_s;
    logic [FCW-1:0]        count_after_s;
    logic [FCW:0]          credit_s;

    assign lut_rd_en  = rd_en_q;
    assign lut_addr   = addr_q;
    assign ltdata     = ltdata_q;
    assign ltvalid    = ltvalid_q;
    assign ltlast     = ltlast_q;
    assign frame_busy = busy_q;
    assign frame_done = done_q;
    assign fsync_err  = err_q;

    // Handshake events and the occupancy the next read must fit into
    always_comb begin
        start_s       = (state_q == S_IDLE) && Fsync;
        pop_s         = ltvalid_q && ltready;
        push_s        = inflight_q;
        count_after_s = count_q + FCW'(push_s) - FCW'(pop_s);
        credit_s      = {1'b0, count_after_s} + {{FCW{1'b0}}, rd_en_q};
    end

    // Frame state machine
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Fsync) state_d = S_STREAM;
                else       state_d = S_IDLE;
            end
            S_STREAM: begin
                if (issue_cnt_q == N_C) state_d = S_DRAIN;
                else                    state_d = S_STREAM;
            end
            S_DRAIN: begin
                if (pop_s && (pop_cnt_q == LAST_C)) state_d = S_DONE;
                else                                state_d = S_DRAIN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read issue; the next strobe is decided one cycle ahead so it is registered
    always_comb begin
        rd_en_d         = 1'b0;
        addr_d          = addr_q;
        issue_cnt_d     = issue_cnt_q;
        inflight_d      = rd_en_q;
        inflight_last_d = rd_en_q && (addr_q == LAST_ADDR_C);
        if (start_s) begin
            rd_en_d     = 1'b1;
            addr_d      = '0;
            issue_cnt_d = CNT_W'(1);
        end else if ((state_q == S_STREAM) && (issue_cnt_q < N_C) && (credit_s < CRED_MAX_C)) begin
            rd_en_d     = 1'b1;
            addr_d      = issue_cnt_q[LUT_AW-1:0];
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end else begin
            rd_en_d     = 1'b0;
        end
    end

    // Prefetch FIFO; the stream registers are loaded from the post-update head
    always_comb begin
        mem_data_d = mem_data_q;
        mem_last_d = mem_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_after_s;
        pop_cnt_d  = pop_cnt_q;
        if (push_s) begin
            mem_data_d[wr_ptr_q] = lut_rdata;
            mem_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
        end else begin
            rd_ptr_d  = rd_ptr_q;
        end
        if (start_s) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pop_cnt_d = '0;
        end else begin
            count_d   = count_after_s;
        end
        ltvalid_d = (count_d != '0);
        if (ltvalid_d) begin
            ltdata_d = mem_data_d[rd_ptr_d];
            ltlast_d = mem_last_d[rd_ptr_d];
        end else begin
            ltdata_d = 8'h00;
            ltlast_d = 1'b0;
        end
    end

    // Status pulses
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = Fsync && (state_q != S_IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rd_en_q         <= 1'b0;
            addr_q          <= '0;
            issue_cnt_q     <= '0;
            pop_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            mem_data_q      <= '{default: 8'h00};
            mem_last_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            ltvalid_q       <= 1'b0;
            ltdata_q        <= 8'h00;
            ltlast_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_en_q         <= rd_en_d;
            addr_q          <= addr_d;
            issue_cnt_q     <= issue_cnt_d;
            pop_cnt_q       <= pop_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            mem_data_q      <= mem_data_d;
            mem_last_q      <= mem_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            ltvalid_q       <= ltvalid_d;
            ltdata_q        <= ltdata_d;
            ltlast_q        <= ltlast_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

endmodule

// File: tb/tb_lut_stream_ctrl.sv
// Directed/random bench for lut_stream_ctrl: a frame-level model tracks what
// must be read, delivered and reported, cycle by cycle.
module tb_lut_stream_ctrl;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 10;
    localparam int D  = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          Fsync;
    logic          lut_rd_en;
    logic [AW-1:0] lut_addr;
    logic [7:0]    lut_rdata;
    logic [7:0]    ltdata;
    logic          ltvalid;
    logic          ltlast;
    logic          ltready;
    logic          frame_busy;
    logic          frame_done;
    logic          fsync_err;

    logic [7:0]    rom [0:(1<<AW)-1];
    logic [7:0]    pat [4];

    int   n_cmp = 0;
    int   n_err = 0;
    int   gcyc = 0;
    bit   busy_m;
    bit   err_exp;
    bit   hold_prev;
    logic [7:0] prev_data;
    logic prev_last;
    int   issued_m, accepted_m, done_at, first_acc, last_acc;
    int   n_last, n_done, n_errp;

    lut_stream_ctrl #(.img_width(W), .img_height(H), .LUT_AW(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .Fsync(Fsync),
        .lut_rd_en(lut_rd_en), .lut_addr(lut_addr), .lut_rdata(lut_rdata),
        .ltdata(ltdata), .ltvalid(ltvalid), .ltlast(ltlast), .ltready(ltready),
        .frame_busy(frame_busy), .frame_done(frame_done), .fsync_err(fsync_err)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency; garbage when not read
    always @(posedge clk) lut_rdata <= lut_rd_en ? rom[lut_addr] : 8'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({lut_rd_en, lut_addr, ltdata, ltvalid, ltlast, frame_busy, frame_done, fsync_err});
    endfunction

    // One clock cycle: check current outputs against the model, then advance it
    task automatic cyc_step(input bit fs, input bit rdy, input bit r);
        bit busy_nx;
        Fsync = fs; ltready = rdy; rst = r;
        chk("busy", 32'(frame_busy), 32'(busy_m));
        chk("done", 32'(frame_done), 32'(gcyc == done_at));
        chk("fsync_err", 32'(fsync_err), 32'(err_exp));
        if (frame_done === 1'b1) n_done++;
        if (fsync_err === 1'b1) n_errp++;
        if (ltvalid !== 1'b1) chk("idle_zero", 32'({ltdata, ltlast}), 32'h0);
        if (hold_prev) chk("axi_hold", 32'({ltvalid, ltdata, ltlast}), 32'({1'b1, prev_data, prev_last}));
        if (lut_rd_en === 1'b1) begin
            chk("rd_addr", 32'(lut_addr), 32'(issued_m));
            chk("rd_credit", 32'(((issued_m - accepted_m) < D) && (issued_m < N)), 32'h1);
            issued_m++;
        end
        if ((ltvalid === 1'b1) && rdy && !r) begin
            chk("no_overrun", 32'(accepted_m < N), 32'h1);
            chk("data", 32'(ltdata), 32'(rom[accepted_m % N]));
            chk("last", 32'(ltlast), 32'(accepted_m == N - 1));
            if (first_acc < 0) first_acc = gcyc;
            last_acc = gcyc;
            if (ltlast === 1'b1) n_last++;
            accepted_m++;
            if (accepted_m == N) done_at = gcyc + 1;
        end
        hold_prev = (ltvalid === 1'b1) && !rdy && !r;
        prev_data = ltdata;
        prev_last = ltlast;
        busy_nx   = busy_m;
        err_exp   = fs && busy_m && !r;
        if (r) begin
            busy_nx = 1'b0; done_at = -1; issued_m = 0; accepted_m = 0; hold_prev = 1'b0;
        end else if (fs && !busy_m) begin
            busy_nx = 1'b1; done_at = -1; issued_m = 0; accepted_m = 0; first_acc = -1;
        end else if (gcyc == done_at) begin
            busy_nx = 1'b0;
        end
        busy_m = busy_nx;
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    // mode 0: ready high; 1: ready low for cycles 0..20; 2: 50% random ready
    task automatic run_frame(input int mode, input bit spur, input bit timing);
        int rel;
        int f0;
        bit fs, rdy;
        rel = 0; f0 = gcyc;
        n_last = 0; n_done = 0; n_errp = 0;
        do begin
            fs = (rel == 0) || (spur && ((rel == 40) || (gcyc == done_at)));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (rel > 20);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if ((mode == 1) && (rel == 21)) begin
                chk("bp_reads", 32'(issued_m), 32'(D));
                chk("bp_head", 32'({ltvalid, ltdata}), 32'({1'b1, rom[0]}));
            end
            if (timing && (rel == 1)) chk("t1_rd_busy", 32'({lut_rd_en, frame_busy, lut_addr}), 32'({2'b11, 10'd0}));
            if (timing && (rel == 3)) chk("t3_valid", 32'(ltvalid), 32'h1);
            cyc_step(fs, rdy, 1'b0);
            rel++;
        end while (busy_m && (rel < 3000));
        chk("frame_timeout", 32'(busy_m), 32'h0);
        cyc_step(1'b0, 1'b1, 1'b0);
        cyc_step(1'b0, 1'b1, 1'b0);
        chk("n_accept", 32'(accepted_m), 32'(N));
        chk("n_last", 32'(n_last), 32'h1);
        chk("n_done", 32'(n_done), 32'h1);
        chk("n_fsync_err", 32'(n_errp), spur ? 32'h2 : 32'h0);
        if (timing) begin
            chk("t_first_acc", 32'(first_acc - f0), 32'h3);
            chk("t_last_acc", 32'(last_acc - f0), 32'(N + 2));
            chk("t_done", 32'(done_at - f0), 32'(N + 3));
        end
    endtask

    initial begin
        rst = 1'b1; Fsync = 1'b0; ltready = 1'b0;
        busy_m = 1'b0; err_exp = 1'b0; hold_prev = 1'b0;
        issued_m = 0; accepted_m = 0; done_at = -1; first_acc = -1; last_acc = -1;
        for (int a = 0; a < (1 << AW); a++) rom[a] = 8'(a);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", all_outs(), 32'h0);

        // streaming without back-pressure, then held-off start
        run_frame(0, 1'b0, 1'b1);
        run_frame(1, 1'b0, 1'b0);

        // random content, random ready, three frames
        for (int a = 0; a < N; a++) rom[a] = 8'($urandom);
        for (int f = 0; f < 3; f++) run_frame(2, 1'b0, 1'b0);

        // spurious syncs mid-frame and in the done cycle
        for (int a = 0; a < N; a++) rom[a] = 8'(a);
        run_frame(0, 1'b1, 1'b1);

        // reset mid-frame at cycle 60, new frame at 70
        n_done = 0;
        for (int rel = 0; rel < 70; rel++) begin
            cyc_step(rel == 0, 1'($urandom_range(0, 1)), rel == 60);
            if (rel == 60) chk("rst_outs", all_outs(), 32'h0);
        end
        chk("abort_no_done", 32'(n_done), 32'h0);
        run_frame(2, 1'b0, 1'b0);

        // signed offsets pass through unmodified
        pat[0] = 8'hF1; pat[1] = 8'h7F; pat[2] = 8'h80; pat[3] = 8'h0E;
        for (int a = 0; a < N; a++) rom[a] = pat[a % 4];
        run_frame(0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lut_stream_ctrl.md
# lut_stream_ctrl

Frame sequencer for the rectification LUT path. On each frame-start pulse it walks the LUT ROM from address 0 to the last entry of the frame and streams the offset bytes to the fetch stage's LUT AXI-stream slave (`ltdata/ltvalid/ltlast/ltready`). A small prefetch FIFO absorbs the ROM read latency and back-pressure. It reports busy, done and spurious-sync status to the top-level control.

## Interface
- `img_width`, 16: pixels per line.
- `img_height`, 8: lines per frame.
- `LUT_AW`, 10: LUT ROM address width. `img_width*img_height` must be ≤ 2^LUT_AW.
- `FIFO_DEPTH`, 4: prefetch FIFO entries, power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `Fsync`  in  1  frame-start pulse, one cycle.
- `lut_rd_en`  out  1  ROM read strobe.
- `lut_addr`  out  LUT_AW  ROM read address.
- `lut_rdata`  in  8  ROM data, valid exactly 1 cycle after `lut_rd_en`.
- `ltdata`  out  8  LUT offset byte (y in [7:4], x in [3:0]; passed through unmodified).
- `ltvalid`  out  1  stream valid.
- `ltlast`  out  1  marks the final entry of the frame.
- `ltready`  in  1  stream ready from the fetch stage.
- `frame_busy`  out  1  high from frame accept until frame done.
- `frame_done`  out  1  one-cycle pulse after the last entry is accepted.
- `fsync_err`  out  1  one-cycle pulse when `Fsync` arrives outside IDLE.

## Operation
Constant: N = img_width*img_height.

State machine:
- **IDLE**
  - `Fsync` → STREAM.
  - On transition: clear `issue_cnt`, `pop_cnt` and `lut_addr` to 0; flush the FIFO.
- **STREAM**
  - Issues reads while credit is available.
  - When the read with `issue_cnt` = N-1 is issued → DRAIN.
- **DRAIN**
  - No further reads.
  - When the pop with `pop_cnt` = N-1 occurs (`ltvalid && ltready && ltlast`) → DONE.
- **DONE**
  - Asserts `frame_done` for one cycle → IDLE.

Read issue (registered outputs):
- Credit rule: `lut_rd_en` is asserted in a cycle only when state is STREAM and `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 1 if `lut_rd_en` was high the previous cycle, else 0.
- `lut_addr` = `issue_cnt` while `lut_rd_en` is high. `issue_cnt` increments on each issue.
- Exactly N reads are issued per frame, addresses 0..N-1 in order. There is no wrap.

FIFO:
- Written the cycle after `lut_rd_en` with `lut_rdata` plus a last tag = (issued index == N-1).
- The FIFO never overflows by construction. An overflow is a design error.
- Stream side:
  - `ltvalid` = FIFO non-empty.
  - `ltdata` and `ltlast` come from the FIFO head. `ltdata` is forced to 0 and `ltlast` to 0 while `ltvalid` is low.
  - Pop on `ltvalid && ltready`.
  - Simultaneous push and pop in one cycle is supported; the count is unchanged.
- AXI rule: once `ltvalid` is high, it and `ltdata`/`ltlast` stay stable until accepted.

Status outputs:
- `frame_busy` = state ≠ IDLE.
- `Fsync` in STREAM, DRAIN or DONE is ignored and pulses `fsync_err` the next cycle. The current frame continues unaffected.
- `Fsync` coincident with `rst` is ignored.

Widths:
- `issue_cnt` and `pop_cnt` are LUT_AW+1 bits, unsigned.
- `fifo_count` is clog2(FIFO_DEPTH)+1 bits.

Reset:
- State goes to IDLE and the FIFO is emptied.
- All outputs go to 0: `lut_rd_en`, `lut_addr`, `ltdata`, `ltvalid`, `ltlast`, `frame_busy`, `frame_done`, `fsync_err`.
- Reset mid-frame aborts the frame: no `frame_done`, and any in-flight ROM data is discarded.

## Timing
- `Fsync` sampled high in IDLE at cycle 0:
  - `frame_busy` = 1 from cycle 1.
  - `lut_rd_en` = 1 with `lut_addr` = 0 at cycle 1.
  - `lut_rdata` valid at cycle 2.
  - `ltvalid` = 1 at cycle 3.
- With `ltready` held high, one entry is issued and one accepted per cycle with no bubbles after fill.
- The last entry (N-1) is accepted at cycle N+2.
- `frame_done` at cycle N+3; `frame_busy` low from cycle N+4.
- A new `Fsync` is accepted from cycle N+4 (IDLE).
- With `ltready` low, reads stop once `fifo_count + inflight` reaches FIFO_DEPTH. Issue resumes in the cycle after the first pop.

## Test plan
- **Streaming, no back-pressure.**
  - Stimulus: img_width=16, img_height=8, ROM[a]=a[7:0]; `Fsync` at cycle 0; `ltready`=1.
  - Required: entries 0..127 accepted on consecutive cycles 3..130; `ltlast` only on entry 127; `frame_done` at cycle 131; `fsync_err` never asserted.
- **Back-pressure and resume.**
  - Stimulus: FIFO_DEPTH=4; `ltready`=0 for cycles 0..20 after `Fsync`, then 1.
  - Required: exactly 4 reads issued then `lut_rd_en` stays low; `ltvalid`/`ltdata`=0x00 stable; after release, sequence 0..127 is intact with no loss or duplicate.
- **Random ready.**
  - Stimulus: `ltready` driven with 50% random pattern over 3 frames.
  - Required: every frame delivers bytes ROM[0..127] in order, one `ltlast` and one `frame_done` per frame; FIFO count never exceeds 4.
- **Spurious sync.**
  - Stimulus: `Fsync` again at cycle 40 of a frame, and `Fsync` in the DONE cycle.
  - Required: `fsync_err` pulses at cycles 41 and done+1; frame output unchanged; no restart.
- **Reset mid-frame.**
  - Stimulus: `rst` at cycle 60, then `Fsync` at cycle 70.
  - Required: all outputs 0 from cycle 61; no `frame_done` for the aborted frame; new frame restarts at address 0 with a complete 0..127 sequence.
- **Signed offsets pass-through.**
  - Stimulus: ROM holds 0xF1, 0x7F, 0x80, 0x0E.
  - Required: `ltdata` reproduces the bytes bit-exactly in order.
